// File: rtl/nic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nic_pkg
// Description : Shared constants for the per-node network interface:
//               packet width, register-select codes and the bit that carries
//               the virtual-channel phase in an outbound packet.
// Revision    : 1.0 - initial release
// ============================================================================
package nic_pkg;

  // Packet / register width. Vectors are big-endian: bit 0 is the MSB.
  localparam int DATA_W = 64;

  // Register select codes on addr[0:1].
  localparam logic [1:0] NIC_IBUF  = 2'b00;  // input channel buffer
  localparam logic [1:0] NIC_ISTAT = 2'b01;  // input channel status
  localparam logic [1:0] NIC_OBUF  = 2'b10;  // output channel buffer
  localparam logic [1:0] NIC_OSTAT = 2'b11;  // output channel status

  // Outbound packet bit that must match the router's current VC phase.
  localparam int NIC_VC_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/nic_chan_buf.sv
`default_nettype none
// ============================================================================
// Module      : nic_chan_buf
// Description : Single-entry channel buffer with a full flag.
//               A write is accepted only while empty; a write while full is
//               dropped without touching the stored data. A clear empties the
//               entry but leaves the data in place (stale reads stay valid).
// Ports       : clk, reset (sync, active-low)
//               i_wr / i_wdata : write strobe and data
//               i_clr          : empty the entry
//               o_data         : stored data
//               o_full         : entry occupied
// Revision    : 1.0 - initial release
// ============================================================================
module nic_chan_buf
  import nic_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [0:WIDTH-1] i_wdata,
  input  logic             i_clr,
  output logic [0:WIDTH-1] o_data,
  output logic             o_full
);

  logic [0:WIDTH-1] r_data;
  logic             r_full;

  // Callers never raise a write and a clear that can both take effect in the
  // same cycle (write needs empty, clear is only meaningful while full), so
  // the priority below only matters for the dropped-write case.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_wr && !r_full) begin
      r_data <= i_wdata;
      r_full <= 1'b1;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/nic_port.sv
`default_nettype none
// ============================================================================
// Module      : nic_port
// Description : Memory-mapped NIC responder. Decodes processor loads/stores
//               on the NIC window and moves 64-bit packets between one
//               single-entry output channel (toward the router) and one
//               single-entry input channel (from the router). Load data is
//               registered and returned one cycle after the request.
// Ports       : clk, reset (sync, active-low)
//               addr[0:1]     : 00 ibuf, 01 istat, 10 obuf, 11 ostat
//               nicdi         : store data
//               nicEN/nicWrEn : access strobe / 1=store, 0=load
//               nicdo         : registered load data
//               net_so/net_ro : send strobe / router ready
//               net_do        : outbound packet
//               net_polarity  : router VC phase
//               net_si/net_ri : router send strobe / NIC ready
//               net_di        : inbound packet
// Revision    : 1.0 - initial release
// ============================================================================
module nic_port
  import nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] nicdi,
  input  logic              nicEN,
  input  logic              nicWrEn,
  output logic [0:DATA_W-1] nicdo,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di
);

  logic              w_load;
  logic              w_store;
  logic              w_obuf_wr;
  logic              w_ibuf_clr;
  logic              w_send;
  logic [0:DATA_W-1] w_out_buf;
  logic              w_out_full;
  logic [0:DATA_W-1] w_in_buf;
  logic              w_in_full;
  logic [0:DATA_W-1] r_nicdo;

  assign w_load  = nicEN & ~nicWrEn;
  assign w_store = nicEN &  nicWrEn;

  // Only the output buffer is writable; stores to the other selects vanish.
  assign w_obuf_wr  = w_store && (addr == NIC_OBUF);
  // Reading the input buffer consumes the packet.
  assign w_ibuf_clr = w_load && (addr == NIC_IBUF);

  // A packet leaves only when its VC bit agrees with the router's phase.
  assign w_send = w_out_full & net_ro & (w_out_buf[NIC_VC_BIT] == net_polarity);

  nic_chan_buf #(.WIDTH(DATA_W)) u_out_chan (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (w_obuf_wr),
    .i_wdata (nicdi),
    .i_clr   (w_send),
    .o_data  (w_out_buf),
    .o_full  (w_out_full)
  );

  // A router send while full is a protocol error; the buffer drops it.
  nic_chan_buf #(.WIDTH(DATA_W)) u_in_chan (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (net_si),
    .i_wdata (net_di),
    .i_clr   (w_ibuf_clr),
    .o_data  (w_in_buf),
    .o_full  (w_in_full)
  );

  // Registered load-data mux; holds its value between loads. Status words
  // carry the flag in the least-significant position (bit DATA_W-1).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_nicdo <= '0;
    end else if (w_load) begin
      case (addr)
        NIC_IBUF:  r_nicdo <= w_in_buf;
        NIC_ISTAT: r_nicdo <= {{(DATA_W-1){1'b0}}, w_in_full};
        NIC_OBUF:  r_nicdo <= w_out_buf;
        default:   r_nicdo <= {{(DATA_W-1){1'b0}}, w_out_full};
      endcase
    end
  end

  assign nicdo  = r_nicdo;
  assign net_so = w_send;
  assign net_do = w_out_buf;
  assign net_ri = ~w_in_full;

endmodule
`default_nettype wire

// File: tb/tb_nic_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_nic_port
// Description : Directed self-checking bench for nic_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nic_port;

  logic        clk;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] nicdi;
  logic        nicEN;
  logic        nicWrEn;
  logic [0:63] nicdo;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [0:63] PKT_A = 64'h0123_4567_89AB_CDEF;  // bit0 = 0
  localparam logic [0:63] PKT_B = 64'hFFFF_0000_FFFF_0000;  // bit0 = 1
  localparam logic [0:63] PKT_C = 64'h8000_0000_0000_0042;  // bit0 = 1
  localparam logic [0:63] PKT_D = 64'hDEAD_BEEF_0000_0001;
  localparam logic [0:63] PKT_E = 64'h1111_2222_3333_4444;
  localparam logic [0:63] PKT_F = 64'h5A5A_A5A5_0F0F_F0F0;
  localparam logic [0:63] PKT_G = 64'h7777_8888_9999_AAAA;
  localparam logic [0:63] ONE   = 64'h1;

  nic_port dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .nicdi        (nicdi),
    .nicEN        (nicEN),
    .nicWrEn      (nicWrEn),
    .nicdo        (nicdo),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled away
  // from the edge and new inputs apply to the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [0:63] obs, input logic [0:63] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle access; the edge at the end of that cycle performs it.
  task automatic access(input logic wr, input logic [1:0] a, input logic [0:63] d);
    nicEN   = 1'b1;
    nicWrEn = wr;
    addr    = a;
    nicdi   = d;
    tick();
    nicEN   = 1'b0;
    nicWrEn = 1'b0;
  endtask

  initial begin
    reset = 1'b0; addr = 2'b00; nicdi = '0; nicEN = 1'b0; nicWrEn = 1'b0;
    net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
    #1;
    tick(); tick();
    reset = 1'b1;
    tick();

    // ---- reset / idle ----
    chk("rst_nicdo",  nicdo, '0);
    chk("rst_net_ri", {63'b0, net_ri}, ONE);
    chk("rst_net_so", {63'b0, net_so}, '0);
    chk("rst_net_do", net_do, '0);
    access(1'b0, 2'b01, '0);
    chk("idle_istat", nicdo, '0);
    access(1'b0, 2'b11, '0);
    chk("idle_ostat", nicdo, '0);

    // ---- ignored store, then immediate send with matching polarity ----
    access(1'b1, 2'b11, PKT_B);
    access(1'b0, 2'b11, '0);
    chk("st11_ignored", nicdo, '0);
    net_ro = 1'b1; net_polarity = 1'b0;
    access(1'b1, 2'b10, PKT_A);
    chk("send_so_n1", {63'b0, net_so}, ONE);
    chk("send_do_n1", net_do, PKT_A);
    tick();
    chk("send_so_n2", {63'b0, net_so}, '0);
    access(1'b0, 2'b11, '0);
    chk("send_ostat", nicdo, '0);
    access(1'b0, 2'b10, '0);
    chk("obuf_read", nicdo, PKT_A);

    // ---- polarity mismatch holds the packet; store while full dropped ----
    net_polarity = 1'b1;
    access(1'b1, 2'b10, PKT_A);
    chk("pol_hold1", {63'b0, net_so}, '0);
    access(1'b1, 2'b10, PKT_B);
    chk("pol_hold2", {63'b0, net_so}, '0);
    chk("drop_do",   net_do, PKT_A);
    access(1'b0, 2'b11, '0);
    chk("full_ostat", nicdo, ONE);
    net_polarity = 1'b0;
    #1;
    chk("pol_match_so", {63'b0, net_so}, ONE);
    tick();
    chk("pol_sent_so", {63'b0, net_so}, '0);
    chk("pol_sent_do", net_do, PKT_A);

    // ---- VC bit 1 goes out when polarity is 1; router not ready holds ----
    net_polarity = 1'b1; net_ro = 1'b0;
    access(1'b1, 2'b10, PKT_C);
    chk("ro0_hold", {63'b0, net_so}, '0);
    net_ro = 1'b1;
    #1;
    chk("vc1_so", {63'b0, net_so}, ONE);
    chk("vc1_do", net_do, PKT_C);
    tick();
    chk("vc1_done", {63'b0, net_so}, '0);

    // ---- receive path ----
    net_si = 1'b1; net_di = PKT_D;
    tick();
    net_si = 1'b0;
    chk("rx_ri_low", {63'b0, net_ri}, '0);
    access(1'b0, 2'b01, '0);
    chk("rx_istat", nicdo, ONE);
    net_si = 1'b1; net_di = PKT_E;
    tick();
    net_si = 1'b0;
    chk("rx_ovr_ri", {63'b0, net_ri}, '0);
    access(1'b0, 2'b00, '0);
    chk("rx_ibuf", nicdo, PKT_D);
    chk("rx_ri_high", {63'b0, net_ri}, ONE);
    access(1'b0, 2'b01, '0);
    chk("rx_istat0", nicdo, '0);

    // ---- load 00 while empty with a packet arriving the same edge ----
    net_si = 1'b1; net_di = PKT_F;
    access(1'b0, 2'b00, '0);
    net_si = 1'b0;
    chk("stale_ibuf", nicdo, PKT_D);
    chk("land_ri",    {63'b0, net_ri}, '0);
    tick();
    chk("hold_nicdo", nicdo, PKT_D);
    access(1'b0, 2'b00, '0);
    chk("land_ibuf", nicdo, PKT_F);

    // ---- reset overrides pending load and a held outbound packet ----
    net_polarity = 1'b1;
    access(1'b1, 2'b10, PKT_A);
    net_si = 1'b1; net_di = PKT_G;
    tick();
    net_si = 1'b0;
    chk("pre_rst_ri", {63'b0, net_ri}, '0);
    reset = 1'b0;
    access(1'b0, 2'b00, '0);
    reset = 1'b1;
    chk("post_rst_nicdo", nicdo, '0);
    chk("post_rst_ri",    {63'b0, net_ri}, ONE);
    chk("post_rst_do",    net_do, '0);
    net_polarity = 1'b0;
    #1;
    chk("post_rst_so",    {63'b0, net_so}, '0);
    access(1'b0, 2'b11, '0);
    chk("post_rst_ostat", nicdo, '0);
    access(1'b0, 2'b00, '0);
    chk("post_rst_ibuf",  nicdo, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
